// File: rtl/lut_loader.sv
// lut_loader: assembles big-endian 4-byte stream words into 26-bit table writes.
module lut_loader #(
  parameter int DATA_W = 26,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] COLLECT = 3'd1;
  localparam logic [2:0] WRITE   = 3'd2;
  localparam logic [2:0] DONE    = 3'd3;
  localparam logic [2:0] ERR     = 3'd4;
  logic [2:0]        state;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-9:0] acc;
  logic              last;
  assign byte_ready = state == COLLECT;
  assign wr_en      = state == WRITE;
  assign busy       = state == COLLECT || state == WRITE;
  assign done       = state == DONE;
  assign err        = state == ERR;
  assign last       = addr == '1;
  // acc keeps only the low DATA_W-8 bits, so byte0's checked-zero upper bits shift out
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr    <= '0;
      acc     <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      case (state)
        COLLECT: if (byte_valid) begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd0 && byte_in[7:2] != 6'd0) state <= ERR;
          else if (cnt == 2'd3) begin
            state   <= WRITE;
            wr_addr <= addr;
            wr_data <= {acc, byte_in};
          end else acc <= {acc[DATA_W-17:0], byte_in};
        end
        WRITE: begin
          state <= last ? DONE : COLLECT;
          addr  <= last ? addr : addr + ADDR_W'(1);
        end
        default: if (start) begin
          state <= COLLECT;
          cnt   <= '0;
          addr  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lut_loader.sv
// tb_lut_loader: random-gap stream loads checked against a queue of expected table writes.
module tb_lut_loader;
  logic        clk = 0, rst = 1, start = 0, byte_valid = 0;
  logic [7:0]  byte_in = 0;
  logic        byte_ready, wr_en, busy, done, err;
  logic [7:0]  wr_addr;
  logic [25:0] wr_data;
  int          n_chk = 0, n_fail = 0, n_wr = 0;
  logic [33:0] exp_q[$];

  lut_loader dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // every write strobe must match the next expected (addr, data); anything else is spurious
  always @(negedge clk) begin
    check("excl_done_err", {31'd0, done & err}, 0);
    if (wr_en === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) check("spurious_wr", {24'd0, wr_addr}, 32'hFFFF_FFFF);
      else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, wr_addr}, {24'd0, e[33:26]});
        check("wr_data", {6'd0, wr_data}, {6'd0, e[25:0]});
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, {31'd0, byte_ready}, 0);
    check({tag, "_wr_en"}, {31'd0, wr_en}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_err"}, {31'd0, err}, 0);
    check({tag, "_wr_addr"}, {24'd0, wr_addr}, 0);
    check({tag, "_wr_data"}, {6'd0, wr_data}, 0);
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 0;
    repeat (gap) @(negedge clk);
    byte_valid = 1;
    byte_in = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (byte_ready !== 1'b1) check("hs_timeout", {31'd0, byte_ready}, 1);
    else @(negedge clk);
    byte_valid = 0;
  endtask

  task automatic send_word(input logic [7:0] a, input logic [25:0] d, input int maxgap);
    exp_q.push_back({a, d});
    send({6'd0, d[25:24]}, $urandom_range(0, maxgap));
    send(d[23:16], $urandom_range(0, maxgap));
    send(d[15:8], $urandom_range(0, maxgap));
    send(d[7:0], $urandom_range(0, maxgap));
    check("wr_en_after_4th", {31'd0, wr_en}, 1);
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    @(negedge clk);
    check_zero("reset");
    rst = 0;
    // single word 00,00,00,05 with valid held high
    pulse_start();
    check("start_ready", {31'd0, byte_ready}, 1);
    check("start_busy", {31'd0, busy}, 1);
    send_word(8'd0, 26'h0000005, 0);
    @(negedge clk);
    check("post_write_wr_en", {31'd0, wr_en}, 0);
    check("post_write_ready", {31'd0, byte_ready}, 1);
    check("hold_wr_data", {6'd0, wr_data}, 32'h5);
    do_reset();
    // full load of addr*3 with random gaps and ignored start pulses
    pulse_start();
    for (int a = 0; a < 256; a++) begin
      if (a == 40) begin
        send({6'd0, 2'(26'(a * 3) >> 24)}, 0);
        exp_q.push_back({8'(a), 26'(a * 3)});
        pulse_start();
        send(8'(26'(a * 3) >> 16), 1);
        send(8'(26'(a * 3) >> 8), 0);
        send(8'(a * 3), 0);
        check("wr_en_mid_start", {31'd0, wr_en}, 1);
      end else send_word(8'(a), 26'(a * 3), (a % 3 == 0) ? 2 : 0);
      if (a == 77) pulse_start();
    end
    @(negedge clk);
    check("load_done", {31'd0, done}, 1);
    check("load_busy", {31'd0, busy}, 0);
    check("load_err", {31'd0, err}, 0);
    check("load_nwr", n_wr, 257);
    check("load_hold_addr", {24'd0, wr_addr}, 255);
    check("load_hold_data", {6'd0, wr_data}, 765);
    byte_valid = 1;
    repeat (3) begin
      @(negedge clk);
      check("done_ready", {31'd0, byte_ready}, 0);
    end
    byte_valid = 0;
    // malformed byte0 on word 7
    pulse_start();
    check("restart_done_clr", {31'd0, done}, 0);
    for (int a = 0; a < 7; a++) send_word(8'(a), 26'($urandom), 1);
    send(8'h04, 1);
    check("err_set", {31'd0, err}, 1);
    check("err_ready", {31'd0, byte_ready}, 0);
    check("err_busy", {31'd0, busy}, 0);
    byte_valid = 1;
    repeat (4) @(negedge clk);
    byte_valid = 0;
    check("err_sticky", {31'd0, err}, 1);
    pulse_start();
    check("err_clr", {31'd0, err}, 0);
    check("err_restart_busy", {31'd0, busy}, 1);
    send_word(8'd0, 26'($urandom), 1);
    do_reset();
    // valid pattern 1,0,0,1,0,1,1 for bytes 03,FF,FF,FF
    pulse_start();
    exp_q.push_back({8'd0, 26'h3FFFFFF});
    send(8'h03, 0);
    send(8'hFF, 2);
    send(8'hFF, 1);
    send(8'hFF, 0);
    check("toggle_wr_en", {31'd0, wr_en}, 1);
    repeat (3) @(negedge clk);
    // reset mid word 10, together with start and valid
    for (int a = 1; a < 10; a++) send_word(8'(a), 26'($urandom), 1);
    send(8'h01, 0);
    send(8'h22, 0);
    rst = 1;
    start = 1;
    byte_valid = 1;
    @(negedge clk);
    rst = 0;
    start = 0;
    check_zero("midrst");
    repeat (3) begin
      @(negedge clk);
      check("midrst_ready", {31'd0, byte_ready}, 0);
    end
    byte_valid = 0;
    pulse_start();
    send_word(8'd0, 26'($urandom), 0);
    repeat (3) @(negedge clk);
    check("pending_writes", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1);
  end
endmodule
